// File: rtl/frame_packer.sv
// frame_packer: packs 2- or 3-bit encoder symbols MSB-first into 276-bit frames.
// The assembly register fills while the output register holds the previous frame.
// Optional feature: define PACKER_PAD_EN to let i_flush zero-pad and close a partial frame.
module frame_packer #(
    parameter int unsigned FRAME_W = 276,
    parameter int unsigned SYM_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_code_rate,
    input  logic [SYM_W-1:0]   i_sym,
    input  logic               i_sym_valid,
    output logic               o_sym_ready,
    input  logic               i_flush,
    output logic [FRAME_W-1:0] o_frame,
    output logic               o_frame_valid,
    input  logic               i_frame_ready,
    output logic [7:0]         o_sym_cnt
);

    typedef enum logic [1:0] {StIdle, StFill, StHold} state_e;

    localparam logic [7:0] SymsRate2 = 8'(FRAME_W / 2);
    localparam logic [7:0] SymsRate3 = 8'(FRAME_W / 3);

`ifdef PACKER_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
    logic unused_flush;
    assign unused_flush = i_flush;
`endif

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               rate_q, rate_d;
    logic [FRAME_W-1:0] asm_q, asm_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               frame_valid_q, frame_valid_d;

    logic               accept;
    logic               frame_hs;
    logic               out_free;
    logic               rate_eff;
    logic [7:0]         syms_per_frame;
    logic [9:0]         shamt;
    logic [SYM_W-1:0]   sym_masked;
    logic [FRAME_W-1:0] asm_wr;
    logic               close;

    assign o_sym_ready   = (state_q != StHold);
    assign o_frame       = frame_q;
    assign o_frame_valid = frame_valid_q;
    assign o_sym_cnt     = cnt_q;

    assign accept   = i_sym_valid && o_sym_ready;
    assign frame_hs = frame_valid_q && i_frame_ready;
    assign out_free = !frame_valid_q || i_frame_ready;

    // Symbol placement: the rate is taken live for the first symbol, latched afterwards.
    always_comb begin
        rate_eff       = (cnt_q == 8'd0) ? i_code_rate : rate_q;
        syms_per_frame = rate_eff ? SymsRate3 : SymsRate2;
        sym_masked     = rate_eff ? i_sym : {1'b0, i_sym[1:0]};
        shamt          = 10'(FRAME_W) - ((10'(cnt_q) + 10'd1) * (rate_eff ? 10'd3 : 10'd2));
        // asm is cleared on every transfer, so OR-ing in a symbol is a write and
        // positions never written stay zero (this is also the flush padding).
        asm_wr         = asm_q | ({{(FRAME_W-SYM_W){1'b0}}, sym_masked} << shamt);
    end

    // Assembly FSM next state, counters and output-register transfer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rate_d        = rate_q;
        asm_d         = asm_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q && !frame_hs;
        close         = 1'b0;

        unique case (state_q)
            StIdle, StFill: begin
                if (accept) begin
                    asm_d   = asm_wr;
                    cnt_d   = cnt_q + 8'd1;
                    rate_d  = rate_eff;
                    state_d = StFill;
                end
                close = (accept && (cnt_q + 8'd1 == syms_per_frame)) ||
                        (PadEn && i_flush && (state_q == StFill));
                if (close) begin
                    if (out_free) begin
                        frame_d       = asm_d;
                        frame_valid_d = 1'b1;
                        asm_d         = '0;
                        cnt_d         = 8'd0;
                        state_d       = StIdle;
                    end else begin
                        cnt_d   = syms_per_frame;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (frame_hs) begin
                    frame_d       = asm_q;
                    frame_valid_d = 1'b1;
                    asm_d         = '0;
                    cnt_d         = 8'd0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset drops any partial and pending frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= 8'd0;
            rate_q        <= 1'b0;
            asm_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rate_q        <= rate_d;
            asm_q         <= asm_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer: directed, table-driven bench for frame_packer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_frame_packer;

    localparam int FW = 276;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          code_rate = 1'b0;
    logic [2:0]    sym = 3'b000;
    logic          sym_valid = 1'b0;
    logic          sym_ready;
    logic          flush = 1'b0;
    logic [FW-1:0] frame;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic [7:0]    sym_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic          rate;
        logic [2:0]    sym;
        logic [FW-1:0] exp;
    } vec_t;

    vec_t          vecs [4];
    logic [FW-1:0] exp_f;

    frame_packer #(.FRAME_W(FW), .SYM_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_code_rate   (code_rate),
        .i_sym         (sym),
        .i_sym_valid   (sym_valid),
        .o_sym_ready   (sym_ready),
        .i_flush       (flush),
        .o_frame       (frame),
        .o_frame_valid (frame_valid),
        .i_frame_ready (frame_ready),
        .o_sym_cnt     (sym_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_frame(input string name, input logic [FW-1:0] act,
                             input logic [FW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive n symbols back to back; frame_ready is rdy, except rdy_last on the final one.
    task automatic send(input logic rate, input logic [2:0] s, input int n,
                        input logic rdy, input logic rdy_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            code_rate   = rate;
            sym         = s;
            sym_valid   = 1'b1;
            frame_ready = (i == n - 1) ? rdy_last : rdy;
        end
        @(negedge clk);
        sym_valid   = 1'b0;
        frame_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = {1'b0, 3'b010, {138{2'b10}}};
        vecs[1] = {1'b1, 3'b101, {92{3'b101}}};
        vecs[2] = {1'b0, 3'b111, {138{2'b11}}};   // bit 2 ignored at rate 1/2
        vecs[3] = {1'b1, 3'b010, {92{3'b010}}};

        // Asynchronous reset state
        #2 rst = 1'b0;
        #1;
        chk_val("rst_valid", int'(frame_valid), 0);
        chk_val("rst_ready", int'(sym_ready), 1);
        chk_val("rst_cnt", int'(sym_cnt), 0);
        chk_frame("rst_frame", frame, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Table: whole frames with the consumer always ready
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].rate, vecs[v].sym, vecs[v].rate ? 92 : 138, 1'b1, 1'b1);
            chk_val($sformatf("tab%0d_valid", v), int'(frame_valid), 1);
            chk_frame($sformatf("tab%0d_frame", v), frame, vecs[v].exp);
            chk_val($sformatf("tab%0d_cnt", v), int'(sym_cnt), 0);
        end

        // Rate 1/3 positional check: 001, 110, then zeros
        exp_f = '0;
        exp_f[275:270] = 6'b001110;
        send(1'b1, 3'b001, 1, 1'b1, 1'b1);
        chk_val("r3_cnt1", int'(sym_cnt), 1);
        send(1'b1, 3'b110, 1, 1'b1, 1'b1);
        send(1'b1, 3'b000, 89, 1'b1, 1'b1);
        chk_val("r3_notyet", int'(frame_valid), 0);
        chk_val("r3_cnt91", int'(sym_cnt), 91);
        send(1'b1, 3'b000, 1, 1'b1, 1'b1);
        chk_val("r3_valid", int'(frame_valid), 1);
        chk_frame("r3_frame", frame, exp_f);

        // Backpressure: two frames with no consumer, then a one-cycle pulse
        @(negedge clk) frame_ready = 1'b1;
        @(negedge clk) frame_ready = 1'b0;
        send(1'b0, 3'b001, 138, 1'b0, 1'b0);
        chk_val("bp_a_valid", int'(frame_valid), 1);
        send(1'b0, 3'b011, 138, 1'b0, 1'b0);
        chk_val("bp_hold_ready", int'(sym_ready), 0);
        chk_val("bp_hold_cnt", int'(sym_cnt), 138);
        chk_frame("bp_hold_frame", frame, {138{2'b01}});
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        chk_val("bp_b_valid", int'(frame_valid), 1);
        chk_frame("bp_b_frame", frame, {138{2'b11}});
        chk_val("bp_b_ready", int'(sym_ready), 1);
        chk_val("bp_b_cnt", int'(sym_cnt), 0);

        // Final accept coinciding with frame handshake: no HOLD
        send(1'b1, 3'b100, 92, 1'b0, 1'b1);
        chk_val("sim_valid", int'(frame_valid), 1);
        chk_frame("sim_frame", frame, {92{3'b100}});
        chk_val("sim_ready", int'(sym_ready), 1);
        chk_val("sim_cnt", int'(sym_cnt), 0);

        // Rate change mid-frame is ignored until the next frame
        send(1'b1, 3'b101, 10, 1'b1, 1'b1);
        send(1'b0, 3'b101, 81, 1'b1, 1'b1);
        chk_val("rc_notyet", int'(frame_valid), 0);
        send(1'b0, 3'b101, 1, 1'b1, 1'b1);
        chk_val("rc_valid", int'(frame_valid), 1);
        chk_frame("rc_frame", frame, {92{3'b101}});

        // Reset mid-frame with a pending output frame
        send(1'b0, 3'b010, 50, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_val("mrst_valid", int'(frame_valid), 0);
        chk_val("mrst_ready", int'(sym_ready), 1);
        chk_val("mrst_cnt", int'(sym_cnt), 0);
        chk_frame("mrst_frame", frame, '0);
        @(negedge clk) rst = 1'b1;
        send(1'b0, 3'b001, 138, 1'b1, 1'b1);
        chk_val("mrst_new_valid", int'(frame_valid), 1);
        chk_frame("mrst_new_frame", frame, {138{2'b01}});

        // Flush of a 5-symbol rate-1/3 partial frame
        @(negedge clk) frame_ready = 1'b1;
        @(negedge clk) frame_ready = 1'b0;
        send(1'b1, 3'b111, 5, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
`ifdef PACKER_PAD_EN
        exp_f = '0;
        exp_f[275:261] = 15'h7fff;
        chk_val("flush_valid", int'(frame_valid), 1);
        chk_frame("flush_frame", frame, exp_f);
        chk_val("flush_cnt", int'(sym_cnt), 0);
`else
        chk_val("flush_valid", int'(frame_valid), 0);
        chk_val("flush_cnt", int'(sym_cnt), 5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
